// File: rtl/centroid_tracker.sv
// centroid_tracker: greedy nearest-centroid track assignment with shift-based smoothing and L1 gating
module centroid_tracker #(
  parameter int ALPHA_SHIFT = 1,
  parameter int GATE_DIST = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] centroids_x_in [8],
  input  logic [9:0]  centroids_y_in [8],
  input  logic [2:0]  num_balls,
  input  logic        data_valid_in,
  output logic        busy_out,
  output logic        data_valid_out,
  output logic [10:0] tracks_x_out [8],
  output logic [9:0]  tracks_y_out [8],
  output logic [7:0]  dropped_count_out
);
  typedef enum logic [1:0] {IDLE, MATCH, COMMIT, DONE} state_t;
  state_t state, state_nx;
  logic [10:0] cx [8];
  logic [10:0] nx [8];
  logic [9:0] cy [8];
  logic [9:0] ny [8];
  logic [2:0] n, prev_n, t, c, best_c, sel_c;
  logic [7:0] claimed;
  logic [11:0] best_d, d, sel_d;
  logic initialized, take, row_end;
  logic signed [12:0] dx, ex;
  logic signed [11:0] dy, ey;
  logic [12:0] adx;
  logic [11:0] ady;
  logic [10:0] smooth_x;
  logic [9:0] smooth_y;

  assign busy_out = state != IDLE;
  assign dx = $signed({2'b0, cx[c]}) - $signed({2'b0, tracks_x_out[t]});
  assign dy = $signed({2'b0, cy[c]}) - $signed({2'b0, tracks_y_out[t]});
  assign adx = dx[12] ? 13'(-dx) : 13'(dx);
  assign ady = dy[11] ? 12'(-dy) : 12'(dy);
  assign d = adx[11:0] + ady;
  assign take = !claimed[c] && d < best_d;
  assign sel_d = take ? d : best_d;
  assign sel_c = take ? c : best_c;
  assign row_end = c == n;
  assign ex = $signed({2'b0, cx[sel_c]}) - $signed({2'b0, tracks_x_out[t]});
  assign ey = $signed({2'b0, cy[sel_c]}) - $signed({2'b0, tracks_y_out[t]});
  assign smooth_x = 11'($signed({2'b0, tracks_x_out[t]}) + (ex >>> ALPHA_SHIFT));
  assign smooth_y = 10'($signed({2'b0, tracks_y_out[t]}) + (ey >>> ALPHA_SHIFT));

  // state register
  always_ff @(posedge clk_in) state <= !rst_in ? IDLE : state_nx;

  // next state: a first frame or a ball-count change skips matching and reseeds
  always_comb begin
    state_nx = state;
    if (state == IDLE && data_valid_in) state_nx = (!initialized || num_balls != prev_n) ? COMMIT : MATCH;
    else if (state == MATCH && row_end && t == n) state_nx = COMMIT;
    else if (state == COMMIT) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end

  // frame latch, one (track, candidate) pair per MATCH cycle, commit and drop counting
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_valid_out <= 1'b0;
      dropped_count_out <= '0;
      initialized <= 1'b0;
      prev_n <= '0;
      n <= '0;
      t <= '0;
      c <= '0;
      best_c <= '0;
      best_d <= '1;
      claimed <= '0;
      for (int i = 0; i < 8; i++) begin
        tracks_x_out[i] <= '0;
        tracks_y_out[i] <= '0;
        cx[i] <= '0;
        cy[i] <= '0;
        nx[i] <= '0;
        ny[i] <= '0;
      end
    end else begin
      data_valid_out <= state == COMMIT;
      if (data_valid_in && state != IDLE && dropped_count_out != 8'hff) dropped_count_out <= dropped_count_out + 1'b1;
      if (state == IDLE && data_valid_in) begin
        cx <= centroids_x_in;
        cy <= centroids_y_in;
        nx <= centroids_x_in;
        ny <= centroids_y_in;
        n <= num_balls;
        claimed <= '0;
        t <= '0;
        c <= '0;
        best_d <= '1;
      end
      if (state == MATCH && row_end) begin
        claimed[sel_c] <= 1'b1;
        nx[t] <= sel_d <= 12'(GATE_DIST) ? smooth_x : cx[sel_c];
        ny[t] <= sel_d <= 12'(GATE_DIST) ? smooth_y : cy[sel_c];
        c <= '0;
        best_d <= '1;
        t <= t + 1'b1;
      end else if (state == MATCH) begin
        c <= c + 1'b1;
        best_d <= sel_d;
        best_c <= sel_c;
      end
      if (state == COMMIT) begin
        for (int i = 0; i < 8; i++) begin
          tracks_x_out[i] <= 3'(i) <= n ? nx[i] : '0;
          tracks_y_out[i] <= 3'(i) <= n ? ny[i] : '0;
        end
        initialized <= 1'b1;
        prev_n <= n;
      end
    end
  end
endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker: directed and randomized frames checked every cycle against a behavioural tracker model
module tb_centroid_tracker;
  localparam int ALPHA = 1;
  localparam int GATE = 64;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [10:0] cxi [8];
  logic [9:0] cyi [8];
  logic [2:0] num_balls = '0;
  logic dvi = 1'b0;
  logic busy, dvo;
  logic [10:0] tx [8];
  logic [9:0] ty [8];
  logic [7:0] dropped;

  int checks = 0;
  int passed = 0;
  int m_tx [8];
  int m_ty [8];
  int p_tx [8];
  int p_ty [8];
  bit m_init = 0;
  int m_prev_n = 0;
  int p_n = 0;
  int m_drop = 0;
  int e = 0;
  int s = -10;
  int busy_end = -10;
  bit pend = 0;
  bit exp_busy = 0;
  bit exp_dv = 0;
  bit mdl_ok = 0;

  centroid_tracker #(.ALPHA_SHIFT(ALPHA), .GATE_DIST(GATE)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .centroids_x_in(cxi), .centroids_y_in(cyi),
    .num_balls(num_balls), .data_valid_in(dvi), .busy_out(busy), .data_valid_out(dvo),
    .tracks_x_out(tx), .tracks_y_out(ty), .dropped_count_out(dropped)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int floor_div(input int v, input int k);
    return v >= 0 ? v / k : -((-v + k - 1) / k);
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  // Model of a whole accepted frame: results are computed at once and released at the commit edge
  task automatic model_frame();
    int n, bd, bc, dd;
    bit claimed [8];
    bit reseed;
    n = int'(num_balls);
    reseed = !m_init || n != m_prev_n;
    for (int i = 0; i < 8; i++) begin
      p_tx[i] = 0;
      p_ty[i] = 0;
      claimed[i] = 0;
    end
    for (int k = 0; k <= n; k++) begin
      if (reseed) begin
        p_tx[k] = int'(cxi[k]);
        p_ty[k] = int'(cyi[k]);
      end else begin
        bd = 1 << 20;
        bc = 0;
        for (int j = 0; j <= n; j++) begin
          dd = iabs(int'(cxi[j]) - m_tx[k]) + iabs(int'(cyi[j]) - m_ty[k]);
          if (!claimed[j] && dd < bd) begin
            bd = dd;
            bc = j;
          end
        end
        claimed[bc] = 1;
        p_tx[k] = bd <= GATE ? m_tx[k] + floor_div(int'(cxi[bc]) - m_tx[k], 1 << ALPHA) : int'(cxi[bc]);
        p_ty[k] = bd <= GATE ? m_ty[k] + floor_div(int'(cyi[bc]) - m_ty[k], 1 << ALPHA) : int'(cyi[bc]);
      end
    end
    s = e;
    busy_end = e + (reseed ? 2 : (n + 1) * (n + 1) + 2);
    pend = 1;
    p_n = n;
  endtask

  // Model timeline: edge e samples inputs; expectations describe the interval after edge e
  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 8; i++) begin
        m_tx[i] = 0;
        m_ty[i] = 0;
      end
      m_init = 0;
      m_prev_n = 0;
      m_drop = 0;
      pend = 0;
      s = -10;
      busy_end = -10;
    end else begin
      if (pend && e == busy_end - 1) begin
        m_tx = p_tx;
        m_ty = p_ty;
        m_init = 1;
        m_prev_n = p_n;
        pend = 0;
      end
      if (dvi) begin
        if (e <= busy_end) m_drop = m_drop < 255 ? m_drop + 1 : 255;
        else model_frame();
      end
    end
    exp_busy = e >= s && e < busy_end;
    exp_dv = e + 1 == busy_end;
    e++;
    mdl_ok = 1;
  end

  // Compare every output on every cycle
  always @(negedge clk_in) begin
    if (mdl_ok) begin
      check("busy", int'(busy), int'(exp_busy));
      check("dv_out", int'(dvo), int'(exp_dv));
      check("dropped", int'(dropped), m_drop);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("track_x%0d", i), int'(tx[i]), m_tx[i]);
        check($sformatf("track_y%0d", i), int'(ty[i]), m_ty[i]);
      end
    end
  end

  task automatic frame(input int n, input int x0, input int y0, input int x1, input int y1);
    @(negedge clk_in);
    num_balls = 3'(n);
    for (int i = 0; i < 8; i++) begin
      cxi[i] = '0;
      cyi[i] = '0;
    end
    cxi[0] = 11'(x0);
    cyi[0] = 10'(y0);
    cxi[1] = 11'(x1);
    cyi[1] = 10'(y1);
    dvi = 1'b1;
    @(negedge clk_in);
    dvi = 1'b0;
  endtask

  task automatic wait_dv(output int lat);
    lat = 1;
    while (!dvo && lat < 300) begin
      @(negedge clk_in);
      lat++;
    end
    check("dv_seen", int'(dvo), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    check("idle_seen", int'(busy), 0);
  endtask

  task automatic expect2(input string tag, input int x0, input int y0, input int x1, input int y1);
    check({tag, "_x0"}, int'(tx[0]), x0);
    check({tag, "_y0"}, int'(ty[0]), y0);
    check({tag, "_x1"}, int'(tx[1]), x1);
    check({tag, "_y1"}, int'(ty[1]), y1);
    check({tag, "_mx0"}, m_tx[0], x0);
    check({tag, "_my0"}, m_ty[0], y0);
    check({tag, "_mx1"}, m_tx[1], x1);
    check({tag, "_my1"}, m_ty[1], y1);
    for (int i = 2; i < 8; i++) begin
      check($sformatf("%s_x%0d", tag, i), int'(tx[i]), 0);
      check($sformatf("%s_y%0d", tag, i), int'(ty[i]), 0);
    end
  endtask

  initial begin
    int lat, v;
    for (int i = 0; i < 8; i++) begin
      cxi[i] = '0;
      cyi[i] = '0;
    end
    repeat (3) @(negedge clk_in);
    check("rst_busy", int'(busy), 0);
    check("rst_dv", int'(dvo), 0);
    check("rst_x0", int'(tx[0]), 0);
    check("rst_drop", int'(dropped), 0);
    rst_in = 1'b1;
    frame(1, 100, 50, 200, 60);
    wait_dv(lat);
    check("t1_lat", lat, 2);
    expect2("t1", 100, 50, 200, 60);
    frame(1, 204, 64, 104, 54);
    wait_dv(lat);
    check("t2_lat", lat, 6);
    expect2("t2", 102, 52, 202, 62);
    frame(0, 100, 50, 0, 0);
    wait_dv(lat);
    check("t3a_lat", lat, 2);
    expect2("t3a", 100, 50, 0, 0);
    frame(0, 97, 50, 0, 0);
    wait_dv(lat);
    check("t3b_lat", lat, 3);
    expect2("t3b", 98, 50, 0, 0);
    frame(0, 400, 50, 0, 0);
    wait_dv(lat);
    expect2("t3c", 400, 50, 0, 0);
    frame(1, 100, 100, 500, 500);
    wait_dv(lat);
    check("t4a_lat", lat, 2);
    frame(1, 90, 100, 110, 100);
    wait_dv(lat);
    check("t4_lat", lat, 6);
    expect2("t4", 95, 100, 110, 100);
    frame(1, 95, 100, 110, 100);
    dvi = 1'b1;
    @(negedge clk_in);
    dvi = 1'b0;
    wait_idle();
    check("t5_drop1", int'(dropped), 1);
    @(negedge clk_in);
    num_balls = 3'd7;
    dvi = 1'b1;
    repeat (300) @(negedge clk_in);
    dvi = 1'b0;
    wait_idle();
    check("t5_drop_sat", int'(dropped), 255);
    frame(7, 10, 10, 20, 20);
    repeat (5) @(negedge clk_in);
    check("t6_busy_before", int'(busy), 1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("t6_busy", int'(busy), 0);
    check("t6_x0", int'(tx[0]), 0);
    check("t6_drop", int'(dropped), 0);
    check("t6_dv", int'(dvo), 0);
    rst_in = 1'b1;
    frame(7, 10, 10, 20, 20);
    wait_dv(lat);
    check("t6_reseed_lat", lat, 2);
    frame(7, 12, 12, 22, 22);
    wait_dv(lat);
    check("t6_match_lat", lat, 66);
    frame(3, 12, 12, 22, 22);
    wait_dv(lat);
    check("t6_nchange_lat", lat, 2);
    for (int it = 0; it < 80; it++) begin
      @(negedge clk_in);
      num_balls = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : 3'(m_prev_n);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          v = m_tx[(i + it) % 8] + int'($urandom_range(0, 80)) - 40;
          cxi[i] = 11'(v < 0 ? 0 : v > 2047 ? 2047 : v);
          v = m_ty[(i + it) % 8] + int'($urandom_range(0, 40)) - 20;
          cyi[i] = 10'(v < 0 ? 0 : v > 1023 ? 1023 : v);
        end else begin
          cxi[i] = 11'($urandom_range(0, 2047));
          cyi[i] = 10'($urandom_range(0, 1023));
        end
      end
      dvi = 1'b1;
      @(negedge clk_in);
      dvi = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
        dvi = 1'b1;
        @(negedge clk_in);
        dvi = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
